nco_sweep_ctrl: RTL

- Frequency-sweep sequencer that drives the 32-bit phase-increment control word of the quarter-LUT sine NCO.
- Steps the control word linearly from a start value to a stop value, holding each value for a programmable dwell. Supports single-shot or repeating sweeps.
- Sits between the host configuration logic and the NCO `control` input. Used for chirp and test-tone generation.

---
 rtl/nco_sweep_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: frequency-sweep sequencer for the NCO phase-increment word.
// Steps control from a start value up to an inclusive stop value, holding each
// value for dwell+1 cycles. The sweep can run once or repeat.
//
// Optional build macro: NCO_SWEEP_TRIANGLE_EN adds the cfg_tri input.
// When cfg_tri is 1, the sweep ramps back down toward start after the up-ramp.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   cfg_valid      configuration offer
//   cfg_ready      configuration accept (1 outside RUN)
//   cfg_start      first control word of the sweep
//   cfg_stop       inclusive upper bound of the sweep
//   cfg_step       increment applied per step
//   cfg_dwell      hold count; each value lasts dwell+1 cycles
//   cfg_tri        triangle sweep enable (only when NCO_SWEEP_TRIANGLE_EN is defined)
//   cfg_repeat     restart at start after each sweep
//   start          launch the sweep from ARMED
//   abort          stop the sweep immediately
//   control        registered control word to the NCO
//   busy           registered, 1 while in RUN
//   done           1-cycle pulse when a non-repeating sweep completes
//   sweep_wrap     1-cycle pulse on each repeat restart
module nco_sweep_ctrl #(
  parameter int W       = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [W-1:0]       cfg_start,
  input  logic [W-1:0]       cfg_stop,
  input  logic [W-1:0]       cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
`ifdef NCO_SWEEP_TRIANGLE_EN
  input  logic               cfg_tri,
`endif
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic [W-1:0]       control,
  output logic               busy,
  output logic               done,
  output logic               sweep_wrap
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       start_q, start_d;
  logic [W-1:0]       stop_q, stop_d;
  logic [W-1:0]       step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               repeat_q, repeat_d;
  logic [W-1:0]       control_q, control_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
`ifdef NCO_SWEEP_TRIANGLE_EN
  logic               tri_q, tri_d;
  logic               down_q, down_d;
  logic [W:0]         diff;
  logic               down_ok;
`endif

  // One extra bit catches the carry so a sweep near the top never wraps low.
  logic [W:0] sum;
  logic       up_ok;

  assign sum   = {1'b0, control_q} + {1'b0, step_q};
  assign up_ok = !sum[W] && (sum[W-1:0] <= stop_q);
`ifdef NCO_SWEEP_TRIANGLE_EN
  // Borrow out of the subtraction ends the down phase just like a carry ends the up phase.
  assign diff    = {1'b0, control_q} - {1'b0, step_q};
  assign down_ok = !diff[W] && (diff[W-1:0] >= start_q);
`endif

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    stop_d    = stop_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    repeat_d  = repeat_q;
    control_d = control_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
    tri_d     = tri_q;
    down_d    = down_q;
`endif
    case (state_q)
      IDLE, ARMED: begin
        // A config offer wins over start in the same cycle.
        if (cfg_valid) begin
          start_d  = cfg_start;
          stop_d   = cfg_stop;
          step_d   = cfg_step;
          dwell_d  = cfg_dwell;
          repeat_d = cfg_repeat;
`ifdef NCO_SWEEP_TRIANGLE_EN
          tri_d    = cfg_tri;
`endif
          state_d  = ARMED;
        end else if (state_q == ARMED && start) begin
          control_d = start_q;
          cnt_d     = dwell_q;
          busy_d    = 1'b1;
          state_d   = RUN;
`ifdef NCO_SWEEP_TRIANGLE_EN
          down_d    = 1'b0;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          control_d = '0;
          busy_d    = 1'b0;
          state_d   = ARMED;
`ifdef NCO_SWEEP_TRIANGLE_EN
          down_d    = 1'b0;
`endif
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = dwell_q;
`ifdef NCO_SWEEP_TRIANGLE_EN
          if (!down_q && up_ok) begin
            control_d = sum[W-1:0];
          end else if ((down_q || tri_q) && down_ok) begin
            // The top value is not repeated: the first down step leaves it directly.
            control_d = diff[W-1:0];
            down_d    = 1'b1;
          end else if (repeat_q) begin
            control_d = start_q;
            wrap_d    = 1'b1;
            down_d    = 1'b0;
          end else begin
            control_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = ARMED;
            down_d    = 1'b0;
          end
`else
          if (up_ok) begin
            control_d = sum[W-1:0];
          end else if (repeat_q) begin
            control_d = start_q;
            wrap_d    = 1'b1;
          end else begin
            control_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = ARMED;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      repeat_q  <= 1'b0;
      control_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
      tri_q     <= 1'b0;
      down_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      repeat_q  <= repeat_d;
      control_q <= control_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
`ifdef NCO_SWEEP_TRIANGLE_EN
      tri_q     <= tri_d;
      down_q    <= down_d;
`endif
    end
  end

  assign cfg_ready  = (state_q != RUN);
  assign control    = control_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sweep_wrap = wrap_q;

endmodule
